spi_arbiter: RTL and testbench



---
 rtl/spi_arbiter_if.sv | 36 +++
 rtl/spi_arbiter.sv | 141 ++++++++++++++
 tb/tb_spi_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side and spi_ctrl-side signals of spi_arbiter.
// slave is the arbiter; master is its environment (requesters + engine).
interface spi_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       dc0;
    logic       dc1;
    logic       lock0;
    logic       lock1;
    logic       ack0;
    logic       ack1;
    logic       spi_en;
    logic [7:0] spi_data;
    logic       spi_fin;
    logic       dc;
    logic       busy;
    logic       owner;

    modport master (
        output req0, req1, data0, data1,
        output dc0, dc1, lock0, lock1,
        output spi_fin,
        input  ack0, ack1, spi_en, spi_data,
        input  dc, busy, owner
    );

    modport slave (
        input  req0, req1, data0, data1,
        input  dc0, dc1, lock0, lock1,
        input  spi_fin,
        output ack0, ack1, spi_en, spi_data,
        output dc, busy, owner
    );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_ctrl byte engine between two requesters.
// Define SPI_ARB_RR_EN for round-robin contention; default is req0 priority.
module spi_arbiter #(
    parameter int unsigned HOLD_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_MAX = 8'(HOLD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RELEASE,
        S_HOLD
    } state_t;

    state_t     state;
    logic       spi_en_q;
    logic [7:0] spi_data_q;
    logic       dc_q;
    logic       ack0_q;
    logic       ack1_q;
    logic       busy_q;
    logic       owner_q;
    logic       last;
    logic       locked;
    logic [7:0] hold_cnt;

    logic       any_req;
    logic       pick;
    logic       sel;
    logic       sel_req;
    logic       sel_lock;
    logic       sel_dc;
    logic [7:0] sel_data;
    logic       grant;
    logic       hold_expired;

    assign any_req = bus.req0 | bus.req1;

`ifdef SPI_ARB_RR_EN
    // On contention the grant goes away from the previous owner.
    assign pick = bus.req1 & (~bus.req0 | ~last);
`else
    logic unused_last;
    assign unused_last = last;
    assign pick = ~bus.req0;
`endif

    // A held lock only ever looks at the current owner.
    assign sel      = (state == S_HOLD) ? owner_q : pick;
    assign sel_req  = sel ? bus.req1  : bus.req0;
    assign sel_lock = sel ? bus.lock1 : bus.lock0;
    assign sel_dc   = sel ? bus.dc1   : bus.dc0;
    assign sel_data = sel ? bus.data1 : bus.data0;

    assign grant = ((state == S_IDLE) & any_req)
                 | ((state == S_HOLD) & sel_req);

    assign hold_expired = (hold_cnt + 8'd1) == HOLD_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            spi_en_q   <= 1'b0;
            spi_data_q <= 8'h00;
            dc_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            last       <= 1'b1;
            locked     <= 1'b0;
            hold_cnt   <= 8'h00;
        end else if (grant) begin
            spi_data_q <= sel_data;
            dc_q       <= sel_dc;
            owner_q    <= sel;
            locked     <= sel_lock;
            busy_q     <= 1'b1;
            hold_cnt   <= 8'h00;
            state      <= S_SEND;
        end else begin
            unique case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                end
                S_SEND: begin
                    spi_en_q <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.spi_fin) begin
                        spi_en_q <= 1'b0;
                        ack0_q   <= ~owner_q;
                        ack1_q   <= owner_q;
                        last     <= owner_q;
                        state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (locked) begin
                        state <= S_HOLD;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!sel_lock || hold_expired) begin
                        hold_cnt <= 8'h00;
                        busy_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    spi_en_q <= 1'b0;
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.spi_en   = spi_en_q;
    assign bus.spi_data = spi_data_q;
    assign bus.dc       = dc_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: vector table, directed contention/lock sequences and
// randomized requesters checked against a transaction-level model.
`timescale 1ns/1ps
module tb_spi_arbiter;
    localparam int TO = 4;
    localparam int NV = 20;
    localparam int NRAND = 1500;

    typedef struct packed {
        logic       en;
        logic [7:0] sd;
        logic       dc;
        logic       ack0;
        logic       ack1;
        logic       busy;
        logic       owner;
    } out_t;

    typedef struct {
        logic       rs, r0, r1;
        logic [7:0] d0, d1;
        logic       c0, c1, l0, l1, fn;
        out_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fin_auto = 1'b0;
    logic fin_a;
    logic fin_m = 1'b0;
    int   fin_lat = 1;
    logic mdl_on = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    spi_arbiter_if bus();

    spi_arbiter #(.HOLD_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.spi_fin = fin_auto ? fin_a : fin_m;

    function automatic out_t cur();
        out_t o;
        o.en    = bus.spi_en;
        o.sd    = bus.spi_data;
        o.dc    = bus.dc;
        o.ack0  = bus.ack0;
        o.ack1  = bus.ack1;
        o.busy  = bus.busy;
        o.owner = bus.owner;
        return o;
    endfunction

    task automatic chk_out(input string nm, input out_t a, input out_t e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got en=%b data=%h dc=%b ack=%b%b busy=%b owner=%b want en=%b data=%h dc=%b ack=%b%b busy=%b owner=%b",
            nm, a.en, a.sd, a.dc, a.ack0, a.ack1, a.busy, a.owner,
            e.en, e.sd, e.dc, e.ack0, e.ack1, e.busy, e.owner);
    endtask

    task automatic chk_val(input string nm, input int a, input int e);
        checks++;
        if (a == e) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    function automatic vec_t v(logic rs, r0, r1, logic [7:0] d0, d1,
                               logic c0, c1, l0, l1, fn,
                               logic en, logic [7:0] sd,
                               logic dc, a0, a1, bz, ow);
        vec_t t;
        t.rs = rs; t.r0 = r0; t.r1 = r1;
        t.d0 = d0; t.d1 = d1;
        t.c0 = c0; t.c1 = c1; t.l0 = l0; t.l1 = l1; t.fn = fn;
        t.e = '{en, sd, dc, a0, a1, bz, ow};
        return t;
    endfunction

    // spi_ctrl stand-in: raises fin for one cycle fin_lat cycles after en
    initial begin
        int n;
        n = 0;
        fin_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!fin_auto) begin
                n = 0;
                fin_a = 1'b0;
            end else if (fin_a) begin
                fin_a = 1'b0;
                n = 0;
            end else if (bus.spi_en) begin
                n++;
                if (n >= fin_lat) fin_a = 1'b1;
            end else begin
                n = 0;
            end
        end
    end

    // Reference model: flags for "byte latched", "engine running",
    // "ack cycle" and "holding lock"; none set means idle.
    logic m_send, m_run, m_ackc, m_hold, m_last, m_lockreq;
    int   m_age;
    out_t m_out;

    task automatic m_reset();
        m_send = 0; m_run = 0; m_ackc = 0; m_hold = 0;
        m_last = 1; m_lockreq = 0; m_age = 0;
        m_out = '0;
    endtask

    task automatic m_grant(input logic w, input logic [7:0] dd,
                           input logic cc, input logic ll);
        m_out.sd = dd;
        m_out.dc = cc;
        m_out.owner = w;
        m_out.busy = 1;
        m_lockreq = ll;
        m_hold = 0;
        m_send = 1;
    endtask

    task automatic m_step();
        logic       r[2];
        logic [7:0] d[2];
        logic       c[2];
        logic       l[2];
        logic       w;
        r[0] = bus.req0;  r[1] = bus.req1;
        d[0] = bus.data0; d[1] = bus.data1;
        c[0] = bus.dc0;   c[1] = bus.dc1;
        l[0] = bus.lock0; l[1] = bus.lock1;
        if (rst) begin
            m_reset();
            return;
        end
        if (m_send) begin
            m_send = 0; m_run = 1; m_out.en = 1;
        end else if (m_run) begin
            if (bus.spi_fin) begin
                m_run = 0; m_ackc = 1; m_out.en = 0;
                if (m_out.owner) m_out.ack1 = 1;
                else m_out.ack0 = 1;
                m_last = m_out.owner;
            end
        end else if (m_ackc) begin
            m_ackc = 0; m_out.ack0 = 0; m_out.ack1 = 0;
            if (m_lockreq) begin
                m_hold = 1; m_age = 0;
            end else begin
                m_out.busy = 0;
            end
        end else if (m_hold) begin
            w = m_out.owner;
            if (r[w]) begin
                m_grant(w, d[w], c[w], l[w]);
            end else begin
                m_age++;
                if (!l[w] || m_age == TO) begin
                    m_hold = 0; m_out.busy = 0;
                end
            end
        end else if (r[0] || r[1]) begin
`ifdef SPI_ARB_RR_EN
            if (r[0] && r[1]) w = !m_last;
            else w = r[1];
`else
            if (r[0]) w = 0;
            else w = 1;
`endif
            m_grant(w, d[w], c[w], l[w]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mdl_on) begin
                chk_out("random", cur(), m_out);
                m_step();
            end
        end
    end

    task automatic clear_reqs();
        bus.req0 = 0; bus.req1 = 0;
        bus.data0 = 8'h00; bus.data1 = 8'h00;
        bus.dc0 = 0; bus.dc1 = 0;
        bus.lock0 = 0; bus.lock1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        fin_auto = 0;
        fin_m = 0;
        rst = 1;
        clear_reqs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic req_step(input logic ack, inout logic r,
                            inout logic [7:0] d, inout logic c,
                            inout logic l);
        if (r && ack) begin
            if ($urandom_range(0, 1) == 1) r = 0;
            else begin
                d = 8'($urandom);
                c = 1'($urandom_range(0, 1));
            end
            l = ($urandom_range(0, 2) == 0);
        end else if (!r && $urandom_range(0, 3) == 0) begin
            r = 1;
            d = 8'($urandom);
            c = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[NV];
        int   got[4];
        int   exp_c[4];
        int   exp_l[4];
        int   n;
        int   c0;

        tv[0]  = v(1,0,0,8'h00,8'h00,0,0,0,0,0, 0,8'h00,0,0,0,0,0);
        tv[1]  = v(0,1,0,8'hAF,8'h00,0,0,0,0,0, 0,8'hAF,0,0,0,1,0);
        tv[2]  = v(0,1,0,8'hAF,8'h00,0,0,0,0,0, 1,8'hAF,0,0,0,1,0);
        tv[3]  = v(0,1,0,8'hAF,8'h00,0,0,0,0,0, 1,8'hAF,0,0,0,1,0);
        tv[4]  = v(0,1,0,8'hAF,8'h00,0,0,0,0,1, 0,8'hAF,0,1,0,1,0);
        tv[5]  = v(0,0,0,8'hAF,8'h00,0,0,0,0,0, 0,8'hAF,0,0,0,0,0);
        tv[6]  = v(0,0,0,8'hAF,8'h00,0,0,0,0,1, 0,8'hAF,0,0,0,0,0);
        tv[7]  = v(0,0,1,8'hAF,8'h5C,0,1,0,1,0, 0,8'h5C,1,0,0,1,1);
        tv[8]  = v(0,0,1,8'hAF,8'h5C,0,1,0,1,1, 1,8'h5C,1,0,0,1,1);
        tv[9]  = v(0,0,1,8'hAF,8'h5C,0,1,0,1,0, 1,8'h5C,1,0,0,1,1);
        tv[10] = v(0,0,1,8'hAF,8'h5C,0,1,0,1,1, 0,8'h5C,1,0,1,1,1);
        tv[11] = v(0,0,0,8'hAF,8'h5C,0,1,0,1,0, 0,8'h5C,1,0,0,1,1);
        tv[12] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h5C,1,0,0,1,1);
        tv[13] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h5C,1,0,0,1,1);
        tv[14] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h5C,1,0,0,1,1);
        tv[15] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h5C,1,0,0,0,1);
        tv[16] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h11,1,0,0,1,0);
        tv[17] = v(0,1,0,8'h11,8'h5C,1,1,0,1,0, 1,8'h11,1,0,0,1,0);
        tv[18] = v(1,1,0,8'h11,8'h5C,1,1,0,1,0, 0,8'h00,0,0,0,0,0);
        tv[19] = v(0,0,0,8'h11,8'h5C,1,1,0,1,1, 0,8'h00,0,0,0,0,0);

`ifdef SPI_ARB_RR_EN
        exp_c = '{'h0A0, 'h1B0, 'h0A1, 'h1B1};
`else
        exp_c = '{'h0A0, 'h0A1, 'h0A2, 'h0A3};
`endif
        exp_l = '{'h022, 'h000, 'h003, 'h199};

        clear_reqs();
        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rs;
            bus.req0 = tv[i].r0;   bus.req1 = tv[i].r1;
            bus.data0 = tv[i].d0;  bus.data1 = tv[i].d1;
            bus.dc0 = tv[i].c0;    bus.dc1 = tv[i].c1;
            bus.lock0 = tv[i].l0;  bus.lock1 = tv[i].l1;
            fin_m = tv[i].fn;
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), cur(), tv[i].e);
        end

        // both requesters held high for four bytes
        do_reset();
        fin_auto = 1; fin_lat = 2;
        bus.req0 = 1; bus.data0 = 8'hA0; bus.dc0 = 0;
        bus.req1 = 1; bus.data1 = 8'hB0; bus.dc1 = 1;
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got[n] = int'({bus.owner, bus.spi_data});
                n++;
                if (bus.ack0) bus.data0 = bus.data0 + 8'd1;
                else bus.data1 = bus.data1 + 8'd1;
            end
        end
        for (int k = 0; k < 4; k++)
            chk_val($sformatf("contend%0d", k), k < n ? got[k] : -1, exp_c[k]);

        // locked three-byte command while req1 waits
        do_reset();
        fin_auto = 1; fin_lat = 3;
        bus.req0 = 1; bus.data0 = 8'h22; bus.dc0 = 0; bus.lock0 = 1;
        bus.req1 = 1; bus.data1 = 8'h99; bus.dc1 = 1; bus.lock1 = 0;
        n = 0; c0 = 0;
        for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got[n] = int'({bus.owner, bus.spi_data});
                n++;
                if (bus.ack1) begin
                    bus.req1 = 0;
                end else begin
                    c0++;
                    if (c0 == 1) bus.data0 = 8'h00;
                    else if (c0 == 2) bus.data0 = 8'h03;
                    else begin
                        bus.req0 = 0;
                        bus.lock0 = 0;
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++)
            chk_val($sformatf("lock%0d", k), k < n ? got[k] : -1, exp_l[k]);

        // randomized requesters against the model
        do_reset();
        m_reset();
        mdl_on = 1;
        fin_auto = 1;
        for (int c = 0; c < NRAND; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            fin_lat = $urandom_range(1, 5);
            req_step(bus.ack0, bus.req0, bus.data0, bus.dc0, bus.lock0);
            req_step(bus.ack1, bus.req1, bus.data1, bus.dc1, bus.lock1);
        end
        @(negedge clk);
        mdl_on = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
